uart_tx_framer: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_baud_gen.sv | 35 +++
 rtl/uart_tx_framer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and line idle level.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: strobes on the last clk of each serial bit; clear holds it at phase 0.
module uart_tx_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to include the parity bit (polarity from PARITY_ODD).
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLKS_PER_BIT must be 2 or more");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end

  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP_BIT = 1'(STOP_BITS - 1);

  uart_tx_state_t              state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic                        stop_cnt_q, stop_cnt_d;
  logic                        tx_out_q, tx_out_d;
  logic                        tx_ready_q, tx_ready_d;
  logic                        tx_busy_q, tx_busy_d;
  logic                        baud_clear;
  logic                        bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  // Holding the counter clear in IDLE aligns every frame's bit phase to its handshake.
  assign baud_clear = (state_q == IDLE);

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(baud_clear),
    .tick_o (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
          state_d    = START;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == LAST_STOP_BIT) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    tx_out_d = UART_LINE_IDLE;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_out_d = parity_d;
`endif
      default: tx_out_d = UART_LINE_IDLE;
    endcase
    tx_ready_d = (state_d == IDLE);
    tx_busy_d  = !tx_ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= UART_LINE_IDLE;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule
